// File: rtl/std_register_pipeline.sv
// Elastic multi-stage register pipeline with valid/ready flow control, bubble collapsing,
// synchronous flush and a registered occupancy count.
module std_register_pipeline #(
    parameter int unsigned STAGES       = 2,
    parameter type         T            = logic,
    parameter T            RESET_VECTOR = T'('0),
    parameter int unsigned COUNT_WIDTH  = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  T                       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output T                       out_data,
    output logic [COUNT_WIDTH-1:0] occupancy
);

    if (STAGES < 1 || STAGES > 32) begin : gen_bad_stages
        $error("std_register_pipeline: STAGES must be within 1..32");
    end

    if (COUNT_WIDTH != $clog2(STAGES + 1)) begin : gen_bad_count_width
        $error("std_register_pipeline: COUNT_WIDTH is derived and must not be overridden");
    end

    logic [STAGES-1:0]      valid_q;
    logic [STAGES-1:0]      valid_d;
    logic [STAGES-1:0]      adv;
    T                       data_q [STAGES];
    T                       data_d [STAGES];
    logic [COUNT_WIDTH-1:0] occ_q;
    logic [COUNT_WIDTH-1:0] occ_d;
    logic                   accept;
    logic                   emit;

    // A slot may advance if it is empty or the slot downstream of it advances; this lets
    // upstream slots close gaps while the output is stalled.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready | ~valid_q[STAGES-1];
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            adv[i] = ~valid_q[i] | adv[i+1];
        end
    end

    // in_ready is also held low while reset is asserted.
    assign in_ready  = adv[0] & ~flush & rst;
    assign out_valid = valid_q[STAGES-1] & ~flush;
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (adv[0]) begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (adv[i]) begin
                    valid_d[i] = valid_q[i-1];
                    data_d[i]  = data_q[i-1];
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !emit) begin
            occ_d = occ_q + COUNT_WIDTH'(1);
        end else if (!accept && emit) begin
            occ_d = occ_q - COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                data_q[i] <= RESET_VECTOR;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            data_q  <= data_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> $stable(out_data));

    assert property (@(posedge clk) disable iff (!rst)
        32'(occ_q) <= STAGES);

    assert property (@(posedge clk) disable iff (!rst)
        $countones(valid_q) == int'(occ_q));

endmodule
